// File: rtl/mem_loader.sv
// mem_loader
//   Byte-stream program loader for the single-cycle core. It parses a host
//   byte stream into instruction-memory word writes and data-memory byte
//   writes, and controls the core's reset line.
//
//   Frame format: CMD [ADDR LEN payload...]
//     0x01 INST : LEN words, 4 bytes each, little-endian
//     0x02 DATA : LEN bytes
//     0x03 RUN  : release the core from reset
//     other     : sets the sticky err flag
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous, active-low reset
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader accepts a byte (always 1 once out of reset)
//   inst_we     instruction memory write strobe, one-cycle pulse
//   inst_addr   instruction memory word index
//   inst_wdata  instruction word
//   data_we     data memory write strobe, one-cycle pulse
//   data_addr   data memory byte address
//   data_wdata  data byte
//   cpu_rst_n   core reset, active-low; held low until a RUN command
//   busy        high whenever a frame is being parsed
//   err         sticky bad-command flag, cleared only by RST
module mem_loader #(
  parameter int INST_ADDR_W = 8,
  parameter int DATA_ADDR_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   inst_we,
  output logic [INST_ADDR_W-1:0] inst_addr,
  output logic [31:0]            inst_wdata,
  output logic                   data_we,
  output logic [DATA_ADDR_W-1:0] data_addr,
  output logic [7:0]             data_wdata,
  output logic                   cpu_rst_n,
  output logic                   busy,
  output logic                   err
);

  localparam logic [7:0] CMD_INST = 8'h01;
  localparam logic [7:0] CMD_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LEN,
    PAYLOAD
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        accept;
  logic        is_inst;
  logic [7:0]  idx;
  logic [7:0]  remaining;
  logic [1:0]  byte_cnt;
  logic [23:0] word;
  logic        unit_done;

  assign accept = in_valid & in_ready;
  assign busy   = (state != IDLE);

  // A unit completes on every DATA byte, but only on the 4th byte of an INST word.
  assign unit_done = !is_inst || (byte_cnt == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && (in_data == CMD_INST || in_data == CMD_DATA)) begin
          next_state = ADDR;
        end
      end
      ADDR: begin
        if (accept) begin
          next_state = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          next_state = (in_data == 8'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept && unit_done && remaining == 8'd1) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The index is kept at full byte width; truncating it onto the address
  // ports gives the modulo-2^ADDR_W wrap for free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_ready   <= 1'b0;
      inst_we    <= 1'b0;
      inst_addr  <= '0;
      inst_wdata <= '0;
      data_we    <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      err        <= 1'b0;
      is_inst    <= 1'b0;
      idx        <= '0;
      remaining  <= '0;
      byte_cnt   <= '0;
      word       <= '0;
    end else begin
      in_ready <= 1'b1;
      inst_we  <= 1'b0;
      data_we  <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == CMD_INST || in_data == CMD_DATA) begin
              is_inst   <= (in_data == CMD_INST);
              cpu_rst_n <= 1'b0;
            end else if (in_data == CMD_RUN) begin
              cpu_rst_n <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          ADDR: begin
            idx <= in_data;
          end
          LEN: begin
            remaining <= in_data;
            byte_cnt  <= 2'd0;
          end
          PAYLOAD: begin
            if (is_inst) begin
              if (byte_cnt == 2'd3) begin
                inst_we    <= 1'b1;
                inst_addr  <= idx[INST_ADDR_W-1:0];
                inst_wdata <= {in_data, word};
                idx        <= idx + 8'd1;
                remaining  <= remaining - 8'd1;
                byte_cnt   <= 2'd0;
              end else begin
                word[8*byte_cnt +: 8] <= in_data;
                byte_cnt              <= byte_cnt + 2'd1;
              end
            end else begin
              data_we    <= 1'b1;
              data_addr  <= idx[DATA_ADDR_W-1:0];
              data_wdata <= in_data;
              idx        <= idx + 8'd1;
              remaining  <= remaining - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
